// File: rtl/dpram_pkg.sv
`default_nettype none
// =============================================================================
// Module   : dpram_pkg
// Brief    : Shared state type and parameter helpers for dual_port_ram_param.
// Revision : 1.0 - initial release
// =============================================================================
package dpram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int nbytes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat == 1) || (rd_lat == 2);
    endfunction

    function automatic bit lanes_ok(input int data_w, input int byte_w);
        return (byte_w > 0) && ((data_w % byte_w) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_clear_fsm.sv
`default_nettype none
// =============================================================================
// Module   : dpram_clear_fsm
// Brief    : IDLE/CLEAR sequencer that sweeps every word address once.
// Revision : 1.0 - initial release
// =============================================================================
module dpram_clear_fsm
    import dpram_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              sweep_we,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        sweep_we    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                sweep_we = 1'b1;
                busy     = 1'b1;
                // Pointer parks on the last word; a new sweep reloads it.
                if (r_ptr == C_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
        endcase
    end

    assign sweep_addr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/dual_port_ram_param.sv
`default_nettype none
// =============================================================================
// Module   : dual_port_ram_param
// Brief    : Single-clock simple dual-port RAM with byte enables, selectable
//            read latency, collision policy and a hardware clear sweep.
// Revision : 1.0 - initial release
// =============================================================================
module dual_port_ram_param
    import dpram_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                BYTE_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter int                DEPTH    = 64,
    parameter int                RD_LAT   = 1,
    parameter bit                BYP_MODE = 1'b0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clr,
    output logic                              busy,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 w_addr,
    input  logic [DATA_W-1:0]                 data,
    input  logic [nbytes(DATA_W, BYTE_W)-1:0] be,
    output logic                              w_err,
    input  logic                              re,
    input  logic [ADDR_W-1:0]                 r_addr,
    output logic [DATA_W-1:0]                 q,
    output logic                              q_valid
);

    localparam int              NBYTES  = nbytes(DATA_W, BYTE_W);
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

    generate
        if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
            $error("dual_port_ram_param: RD_LAT must be 1 or 2");
        end
        if (!lanes_ok(DATA_W, BYTE_W)) begin : g_bad_lanes
            $error("dual_port_ram_param: DATA_W must be a multiple of BYTE_W");
        end
        if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_depth
            $error("dual_port_ram_param: DEPTH out of range for ADDR_W");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_sweep_we;

    dpram_clear_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_fsm (
        .clock      (clock),
        .reset      (reset),
        .clr        (clr),
        .sweep_addr (w_sweep_addr),
        .sweep_we   (w_sweep_we),
        .busy       (busy)
    );

    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_collide;
    logic [DATA_W-1:0] w_rd_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd_word;

    assign w_wr_in_range = {1'b0, w_addr} < C_DEPTH;
    assign w_rd_in_range = {1'b0, r_addr} < C_DEPTH;
    assign w_wr_ok       = we && !busy && w_wr_in_range;
    assign w_rd_ok       = re && !busy;
    assign w_collide     = w_wr_ok && w_rd_ok && (r_addr == w_addr);
    assign w_rd_old      = w_rd_in_range ? r_mem[r_addr] : '0;

    // Word as it will look after this edge's write, for write-through reads.
    always_comb begin
        w_merged = w_rd_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                w_merged[i*BYTE_W +: BYTE_W] = data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign w_rd_word = (BYP_MODE && w_collide) ? w_merged : w_rd_old;

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_sweep_we) begin
                r_mem[w_sweep_addr] <= INIT_VAL;
            end else if (w_wr_ok) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (be[i]) begin
                        r_mem[w_addr][i*BYTE_W +: BYTE_W] <= data[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    logic [DATA_W-1:0] r_q1;
    logic              r_q1_valid;
    logic              r_w_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q1       <= '0;
            r_q1_valid <= 1'b0;
            r_w_err    <= 1'b0;
        end else begin
            r_q1_valid <= w_rd_ok;
            r_w_err    <= we && (busy || !w_wr_in_range);
            if (w_rd_ok) begin
                r_q1 <= w_rd_word;
            end
        end
    end

    assign w_err = r_w_err;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_q2;
            logic              r_q2_valid;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_q2       <= '0;
                    r_q2_valid <= 1'b0;
                end else begin
                    r_q2_valid <= r_q1_valid;
                    if (r_q1_valid) begin
                        r_q2 <= r_q1;
                    end
                end
            end

            assign q       = r_q2;
            assign q_valid = r_q2_valid;
        end else begin : g_lat1
            assign q       = r_q1;
            assign q_valid = r_q1_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_param.sv
`default_nettype none
// =============================================================================
// Module   : tb_dual_port_ram_param
// Brief    : Self-checking bench for two RAM configurations driven in lockstep.
// Revision : 1.0 - initial release
// =============================================================================
module tb_dual_port_ram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, we, re;
    logic [5:0]  w_addr, r_addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        busy_a, w_err_a, q_valid_a;
    logic [31:0] q_a;
    logic        busy_b, w_err_b, q_valid_b;
    logic [15:0] q_b;

    // A: 32-bit, 40 words, latency 1, read-old. B: 16-bit, 64 words, latency 2, write-through.
    dual_port_ram_param #(
        .DATA_W(32), .BYTE_W(8), .ADDR_W(6), .DEPTH(40),
        .RD_LAT(1), .BYP_MODE(1'b0), .INIT_VAL(32'hA5A5_A5A5)
    ) dut_a (
        .clock(clk), .reset(rst), .clr(clr), .busy(busy_a),
        .we(we), .w_addr(w_addr), .data(wdata), .be(be), .w_err(w_err_a),
        .re(re), .r_addr(r_addr), .q(q_a), .q_valid(q_valid_a)
    );

    dual_port_ram_param #(
        .DATA_W(16), .BYTE_W(8), .ADDR_W(6), .DEPTH(64),
        .RD_LAT(2), .BYP_MODE(1'b1), .INIT_VAL(16'h00A5)
    ) dut_b (
        .clock(clk), .reset(rst), .clr(clr), .busy(busy_b),
        .we(we), .w_addr(w_addr), .data(wdata[15:0]), .be(be[1:0]), .w_err(w_err_b),
        .re(re), .r_addr(r_addr), .q(q_b), .q_valid(q_valid_b)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: whole-array contents, sweep countdown, results keyed by due cycle.
    int          m_depth [2] = '{40, 64};
    int          m_lat   [2] = '{1, 2};
    int          m_byp   [2] = '{0, 1};
    int          m_nb    [2] = '{4, 2};
    logic [31:0] m_init  [2] = '{32'hA5A5_A5A5, 32'h0000_00A5};
    logic [31:0] m_mem   [2][64];
    int          busy_left [2] = '{0, 0};
    logic        exp_werr  [2];
    logic        slot_v    [2][4];
    logic [31:0] slot_d    [2][4];
    logic [31:0] last_q    [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input int k, input logic [31:0] old,
                                          input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < m_nb[k]; i++) begin
            if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic fill(input int k);
        for (int a = 0; a < 64; a++) m_mem[k][a] = m_init[k];
    endtask

    task automatic model_edge(input int k);
        logic        bsy;
        logic [31:0] v;
        int          due;
        if (rst) begin
            busy_left[k] = m_depth[k];
            exp_werr[k]  = 1'b0;
            last_q[k]    = '0;
            for (int s = 0; s < 4; s++) slot_v[k][s] = 1'b0;
            fill(k);
            return;
        end
        bsy = busy_left[k] > 0;
        exp_werr[k] = we && (bsy || (int'(w_addr) >= m_depth[k]));
        if (re && !bsy) begin
            if (int'(r_addr) >= m_depth[k]) begin
                v = '0;
            end else begin
                v = m_mem[k][r_addr];
                if ((m_byp[k] != 0) && we && (w_addr == r_addr)) v = merge(k, v, wdata, be);
            end
            due = (cyc + m_lat[k] - 1) % 4;
            slot_v[k][due] = 1'b1;
            slot_d[k][due] = v;
        end
        if (we && !bsy && (int'(w_addr) < m_depth[k]))
            m_mem[k][w_addr] = merge(k, m_mem[k][w_addr], wdata, be);
        if (bsy) begin
            busy_left[k]--;
        end else if (clr) begin
            busy_left[k] = m_depth[k];
            fill(k);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] qo [2];
        logic        vo [2], bo [2], eo [2];
        qo[0] = q_a;         vo[0] = q_valid_a; bo[0] = busy_a; eo[0] = w_err_a;
        qo[1] = 32'(q_b);    vo[1] = q_valid_b; bo[1] = busy_b; eo[1] = w_err_b;
        for (int k = 0; k < 2; k++) begin
            int s;
            s = cyc % 4;
            check($sformatf("busy%0d@%0d", k, cyc), 32'(bo[k]), 32'(busy_left[k] > 0));
            check($sformatf("w_err%0d@%0d", k, cyc), 32'(eo[k]), 32'(exp_werr[k]));
            if (slot_v[k][s]) begin
                check($sformatf("q_valid%0d@%0d", k, cyc), 32'(vo[k]), 32'd1);
                check($sformatf("q%0d@%0d", k, cyc), qo[k], slot_d[k][s]);
                last_q[k]    = slot_d[k][s];
                slot_v[k][s] = 1'b0;
            end else begin
                check($sformatf("q_valid%0d@%0d", k, cyc), 32'(vo[k]), 32'd0);
                check($sformatf("q_hold%0d@%0d", k, cyc), qo[k], last_q[k]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_outputs();
        cyc++;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1'b1; w_addr = a; wdata = d; be = b;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        re = 1'b1; r_addr = a;
        step();
        re = 1'b0;
    endtask

    task automatic wait_idle(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < 300; i++) begin
            if (!busy_a && !busy_b) break;
            if (busy_a) na++;
            if (busy_b) nb++;
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb;
        rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
        w_addr = '0; r_addr = '0; wdata = '0; be = '0;
        step();
        step();
        rst = 1'b0;

        // Sweep length after reset equals DEPTH for each instance.
        wait_idle(na, nb);
        check("sweep_len_a", 32'(na), 32'd40);
        check("sweep_len_b", 32'(nb), 32'd64);

        rd(6'd0);  check("init0_a", q_a, 32'hA5A5_A5A5);
        step();    check("init0_b", 32'(q_b), 32'h00A5);
        rd(6'd31); check("init31_a", q_a, 32'hA5A5_A5A5);
        rd(6'd63); check("oor63_a", q_a, 32'h0); check("oor63_va", 32'(q_valid_a), 32'd1);
        step();    check("init63_b", 32'(q_b), 32'h00A5);

        wr(6'd5, 32'h0000_00FF, 4'hF);
        rd(6'd5);  check("wr5_a", q_a, 32'h0000_00FF);
        step();    check("wr5_b", 32'(q_b), 32'h00FF); check("wr5_vb", 32'(q_valid_b), 32'd1);

        wr(6'd9, 32'h1122_3344, 4'hF);
        wr(6'd9, 32'hAABB_CCDD, 4'b0101);
        rd(6'd9);  check("be_a", q_a, 32'h11BB_33DD);
        step();    check("be_b", 32'(q_b), 32'h33DD);

        wr(6'd7, 32'h0000_0010, 4'hF);
        we = 1'b1; w_addr = 6'd7; wdata = 32'h0000_0020; be = 4'hF;
        re = 1'b1; r_addr = 6'd7;
        step();    check("coll_old_a", q_a, 32'h0000_0010);
        we = 1'b0; re = 1'b0;
        step();    check("coll_new_b", 32'(q_b), 32'h0020);
        rd(6'd7);  check("after_coll_a", q_a, 32'h0000_0020);

        wr(6'd50, 32'hDEAD_BEEF, 4'hF);
        check("range_werr_a", 32'(w_err_a), 32'd1);
        check("range_werr_b", 32'(w_err_b), 32'd0);
        rd(6'd50); check("range_rd_a", q_a, 32'h0); check("range_rd_va", 32'(q_valid_a), 32'd1);
        step();    check("range_rd_b", 32'(q_b), 32'hBEEF);

        // Read issued with the accepted clr still completes; then writes/reads bounce.
        clr = 1'b1; re = 1'b1; r_addr = 6'd5;
        step();    check("rd_with_clr_a", q_a, 32'h0000_00FF);
        clr = 1'b0; re = 1'b0;
        repeat (5) step();
        wr(6'd0, 32'h1234_5678, 4'hF);
        check("busy_werr_a", 32'(w_err_a), 32'd1);
        check("busy_werr_b", 32'(w_err_b), 32'd1);
        rd(6'd5);  check("busy_rd_va", 32'(q_valid_a), 32'd0);
        wait_idle(na, nb);
        check("busy_done_a", 32'(busy_a), 32'd0);
        rd(6'd0);  check("busy_drop_a", q_a, 32'hA5A5_A5A5);

        wr(6'd3, 32'h0000_0077, 4'hF);
        rd(6'd3);  check("fill3_a", q_a, 32'h0000_0077);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_idle(na, nb);
        check("restart_len_a", 32'(na), 32'd40);
        check("restart_len_b", 32'(nb), 32'd64);
        rd(6'd3);  check("cleared3_a", q_a, 32'hA5A5_A5A5);
        step();    check("cleared3_b", 32'(q_b), 32'h00A5);

        for (int i = 0; i < 800; i++) begin
            we     = 1'($urandom);
            w_addr = 6'($urandom_range(0, 63));
            wdata  = $urandom;
            be     = 4'($urandom);
            re     = 1'($urandom);
            r_addr = (($urandom % 4) == 0) ? w_addr : 6'($urandom_range(0, 63));
            clr    = (($urandom % 100) == 0);
            rst    = (($urandom % 300) == 0);
            step();
        end
        we = 1'b0; re = 1'b0; clr = 1'b0; rst = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
